// File: rtl/pwm_pkg.sv
// Shared definitions for the SPWM generator / PWM demodulator pair.
// Holds the default counter and duty widths (matched to the generator's
// carrier and LUT widths), the demodulator state encoding and the full-scale
// duty constant for the default width.
package pwm_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_DUTY_W = 8;
  localparam int DUTY_MAX   = (1 << DEF_DUTY_W) - 1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, DUTY_W cycles.
// The caller guarantees that the upper CNT_W bits of the dividend are smaller
// than the divisor, so the quotient fits in DUTY_W bits and the division can
// start with those upper bits already loaded as the partial remainder.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load dividend/divisor and begin (ignored while busy)
//   abort      : drop the division in progress, no done is produced
//   dividend   : CNT_W+DUTY_W bits, unsigned
//   divisor    : CNT_W bits, unsigned, non-zero
//   busy       : high for exactly DUTY_W cycles after start
//   done       : high during the final iteration
//   quotient   : final quotient, meaningful only while done is high
module pwm_div_seq #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_W+DUTY_W-1:0]  dividend,
  input  logic [CNT_W-1:0]         divisor,
  output logic                     busy,
  output logic                     done,
  output logic [DUTY_W-1:0]        quotient
);

  localparam int IW = $clog2(DUTY_W);

  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dvs;
  logic [DUTY_W-1:0] lo;
  logic [DUTY_W-2:0] q;
  logic [IW-1:0]     iter;

  logic [CNT_W:0]    shifted;
  logic              ge;
  logic [CNT_W-1:0]  rem_next;
  logic [DUTY_W-1:0] q_next;

  // Remainder stays below the divisor, so after the subtract the true
  // difference fits CNT_W bits and modular subtraction is exact.
  always_comb begin
    shifted  = {rem, lo[DUTY_W-1]};
    ge       = (shifted >= {1'b0, dvs});
    rem_next = ge ? (shifted[CNT_W-1:0] - dvs) : shifted[CNT_W-1:0];
    q_next   = {q, ge};
  end

  assign done     = busy && (iter == IW'(DUTY_W - 1));
  assign quotient = q_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      rem  <= '0;
      dvs  <= '0;
      lo   <= '0;
      q    <= '0;
      iter <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      rem  <= dividend[CNT_W+DUTY_W-1:DUTY_W];
      lo   <= dividend[DUTY_W-1:0];
      dvs  <= divisor;
      q    <= '0;
      iter <= '0;
    end else if (busy) begin
      rem  <= rem_next;
      lo   <= {lo[DUTY_W-2:0], 1'b0};
      q    <= q_next[DUTY_W-2:0];
      iter <= iter + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: measures period and high time of each carrier cycle of an
// asynchronous PWM input and recovers duty = floor(high * 2^DUTY_W / period).
// One sample plus valid strobe per carrier period; a line without rising
// edges for TIMEOUT cycles yields a single stuck-qualified sample.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   pwm_in     : asynchronous PWM input
//   duty       : recovered duty, held until the next valid
//   period     : last captured period in cycles (0 on stuck)
//   high_time  : last captured high time in cycles (0 on stuck)
//   valid      : one-cycle strobe, duty/period/high_time updated
//   stuck      : qualifies valid; sample came from the timeout
//   overrun    : sticky; an edge arrived while the divider was busy
//   busy       : divider active
module pwm_demod import pwm_pkg::*; #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DUTY_W      = DEF_DUTY_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              stuck,
  output logic              overrun,
  output logic              busy
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   s_d;
  logic                   rise;

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       pcnt;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       cap_period;
  logic [CNT_W-1:0]       cap_high;

  logic                   timeout_hit;
  logic                   div_start;
  logic                   div_done;
  logic [DUTY_W-1:0]      div_q;

  // Input synchroniser, then one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      s_d     <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_in};
      s_d     <= s;
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // A rise in the same cycle as the timeout count means the line is alive,
  // so the edge takes priority over the stuck declaration.
  assign timeout_hit = (state == MEASURE) && !rise && (pcnt == CNT_W'(TIMEOUT));
  assign div_start   = (state == MEASURE) && rise && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rise)        state_n = MEASURE;
      MEASURE: if (timeout_hit) state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  // Period/high counters and capture of the completed measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      hcnt       <= '0;
      cap_period <= '0;
      cap_high   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (rise) begin
        pcnt <= CNT_W'(1);
        hcnt <= CNT_W'(1);
      end else if (state == MEASURE) begin
        pcnt <= pcnt + 1'b1;
        if (s) hcnt <= hcnt + 1'b1;
      end
      if (div_start) begin
        cap_period <= pcnt;
        cap_high   <= hcnt;
      end
      if ((state == MEASURE) && rise && busy) overrun <= 1'b1;
    end
  end

  pwm_div_seq #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (timeout_hit),
    .dividend ({hcnt, {DUTY_W{1'b0}}}),
    .divisor  (pcnt),
    .busy     (busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // Output sample register; the stuck result wins over a finishing division
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      stuck     <= 1'b0;
      duty      <= '0;
      period    <= '0;
      high_time <= '0;
    end else begin
      valid <= 1'b0;
      if (timeout_hit) begin
        valid     <= 1'b1;
        stuck     <= 1'b1;
        duty      <= s ? {DUTY_W{1'b1}} : '0;
        period    <= '0;
        high_time <= '0;
      end else if (div_done) begin
        valid     <= 1'b1;
        stuck     <= 1'b0;
        duty      <= div_q;
        period    <= cap_period;
        high_time <= cap_high;
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod. The reference model works on the pin waveform itself:
// it measures period/high time between pin rising edges with plain integer
// arithmetic and schedules each expected sample at a fixed pipeline offset.
// TIMEOUT is set to 300 so the 255-cycle carrier cases do not time out.
module tb_pwm_demod;
  import pwm_pkg::*;

  localparam int CW  = 16;
  localparam int DW  = 8;
  localparam int SS  = 2;
  localparam int TO  = 300;
  localparam int LAT = SS + DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pwm_in = 1'b0;
  logic [DW-1:0] duty;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          stuck;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  pwm_demod #(
    .CNT_W       (CW),
    .DUTY_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT     (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stuck     (stuck),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    int            cyc;
    logic          stk;
    logic [DW-1:0] d;
    logic [CW-1:0] p;
    logic [CW-1:0] h;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model state, in pin-cycle time
  bit   measuring = 0;
  int   lr = 0;
  int   hc = 0;
  bit   acc_valid = 0;
  int   last_acc = 0;
  bit   prev = 0;
  bit   ovr_set = 0;
  int   ovr_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model(input logic v, input logic r);
    exp_t e;
    bit   rs;
    if (!r) begin
      measuring = 0;
      prev      = 0;
      acc_valid = 0;
      ovr_set   = 0;
      q.delete();
      return;
    end
    rs   = v && !prev;
    prev = v;
    if (rs) begin
      if (measuring) begin
        if (!acc_valid || (cyc - last_acc) >= DW + 1) begin
          e.cyc = cyc + LAT;
          e.stk = 1'b0;
          e.d   = DW'((longint'(hc) * (longint'(1) << DW)) / longint'(cyc - lr));
          e.p   = CW'(cyc - lr);
          e.h   = CW'(hc);
          q.push_back(e);
          acc_valid = 1;
          last_acc  = cyc;
        end else if (!ovr_set) begin
          ovr_set = 1;
          ovr_cyc = cyc + SS + 1;
        end
      end
      measuring = 1;
      lr        = cyc;
      hc        = 1;
    end else if (measuring) begin
      if (cyc - lr == TO) begin
        while (q.size() > 0 && q[$].cyc >= cyc + SS + 1) void'(q.pop_back());
        e.cyc = cyc + SS + 1;
        e.stk = 1'b1;
        e.d   = v ? DW'(DUTY_MAX) : '0;
        e.p   = '0;
        e.h   = '0;
        q.push_back(e);
        measuring = 0;
        acc_valid = 0;
      end else if (v) begin
        hc++;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missed_sample", 64'(e.cyc), 64'(cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check($sformatf("sample(P=%0d,H=%0d,stk=%0b)", e.p, e.h, e.stk),
            64'({valid, stuck, duty, period, high_time}),
            64'({1'b1, e.stk, e.d, e.p, e.h}));
    end else if (valid) begin
      check("spurious_valid", 64'(valid), 64'(0));
    end
  endtask

  task automatic tick(input logic v, input logic r);
    @(posedge clk);
    cyc++;
    #1;
    pwm_in = v;
    rst_n  = r;
    model(v, r);
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) tick(i < h, 1'b1);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v, 1'b1);
  endtask

  function automatic logic exp_ovr();
    return ovr_set && (cyc >= ovr_cyc);
  endfunction

  initial begin
    int p;
    int h;

    // Reset held with the input toggling
    for (int i = 0; i < 8; i++) tick(i[0], 1'b0);
    check("rst_valid",   64'(valid),     64'(0));
    check("rst_stuck",   64'(stuck),     64'(0));
    check("rst_duty",    64'(duty),      64'(0));
    check("rst_period",  64'(period),    64'(0));
    check("rst_high",    64'(high_time), 64'(0));
    check("rst_overrun", 64'(overrun),   64'(0));
    check("rst_busy",    64'(busy),      64'(0));

    // Steady carrier, then the SPWM-rate corner cases
    run(10, 3, 6);
    run(255, 128, 3);
    run(255, 1, 3);
    run(255, 254, 3);

    // Randomised periods at or above the loss-free minimum
    for (int k = 0; k < 6; k++) begin
      p = $urandom_range(200, DW + 1);
      h = $urandom_range(p - 1, 1);
      run(p, h, 3);
    end
    check("overrun_idle", 64'(overrun), 64'(exp_ovr()));

    // Line stuck high, then resume, then line stuck low, then resume
    hold(1'b1, TO + 20);
    run(20, 5, 3);
    hold(1'b0, TO + 20);
    run(20, 5, 3);

    // Reset in the middle of a division
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    check("busy_before_rst", 64'(busy), 64'(1));
    tick(1'b0, 1'b0);
    check("midrst_busy",   64'(busy),      64'(0));
    check("midrst_valid",  64'(valid),     64'(0));
    check("midrst_duty",   64'(duty),      64'(0));
    check("midrst_period", 64'(period),    64'(0));
    check("midrst_high",   64'(high_time), 64'(0));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    run(20, 5, 4);

    // Period shorter than the divider latency
    check("overrun_before", 64'(overrun), 64'(exp_ovr()));
    run(6, 2, 6);
    check("overrun_after", 64'(overrun), 64'(1));
    check("overrun_model", 64'(overrun), 64'(exp_ovr()));
    hold(1'b0, 30);
    check("overrun_sticky", 64'(overrun), 64'(1));
    check("queue_drained", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
